// File: rtl/fht_frame_sched.sv
// Frame sequencer around an FHT core: loads N = 4*2^A_BIT points into four banks,
// starts the transform, waits for completion and streams the result back out.
module fht_frame_sched #(
    parameter int unsigned A_BIT       = 8,
    parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iABORT,

    input  logic             iLOAD_VALID,
    output logic             oLOAD_READY,
    output logic             oLD_WE,
    output logic [1:0]       oLD_BANK,
    output logic [A_BIT-1:0] oLD_ADDR,

    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    input  logic             iFHT_SOURCE,

    input  logic             iUNL_READY,
    output logic             oUNL_RD,
    output logic [1:0]       oUNL_BANK,
    output logic [A_BIT-1:0] oUNL_ADDR,
    output logic             oUNL_SET,
    output logic             oUNL_VALID,
    output logic             oUNL_LAST,

    output logic [1:0]       oRAM_OWNER,
    output logic             oFRAME_DONE,
    output logic             oBUSY,
    output logic             oERR,
    output logic [2:0]       oSTATE
);

    localparam int unsigned    CW       = A_BIT + 2;
    localparam logic [CW-1:0]  LAST_IDX = {CW{1'b1}};
    localparam logic [15:0]    TMO_LAST = TIMEOUT_CYC - 16'd1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_UNLOAD = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   ld_cnt;
    logic [CW-1:0]   unl_cnt;
    logic [15:0]     tmo_cnt;
    logic            result_set;
    logic            err_q;
    logic            unl_valid_q;
    logic            unl_last_q;

    logic            ld_we;
    logic            ld_last;
    logic            unl_rd;
    logic            unl_last_rd;
    logic            run_first;
    logic            fht_done;
    logic            tmo_hit;
    logic            tmo_exit;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // ready never depends on valid, and an accepted beat is never retracted.
    assign ld_we       = iLOAD_VALID && (state == S_LOAD);
    assign ld_last     = ld_we && (ld_cnt == LAST_IDX);
    assign unl_rd      = iUNL_READY && (state == S_UNLOAD);
    assign unl_last_rd = unl_rd && (unl_cnt == LAST_IDX);

    // The FHT core may still show RDY on the cycle right after START, so the
    // first RUN cycle (timer still at zero) cannot signal completion.
    assign run_first = (tmo_cnt == 16'd0);
    assign fht_done  = (state == S_RUN) && !run_first && iFHT_RDY;
    assign tmo_hit   = (tmo_cnt >= TMO_LAST);
    assign tmo_exit  = ((state == S_RUN) && !iABORT && !fht_done && tmo_hit) ||
                       ((state == S_DRAIN) && !iFHT_RDY && tmo_hit);

    // State register
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort outranks every other exit
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (iFHT_RDY) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (iABORT)       state_nxt = S_IDLE;
                else if (ld_last) state_nxt = S_START;
            end
            S_START: begin
                if (iABORT) state_nxt = S_IDLE;
                else        state_nxt = S_RUN;
            end
            S_RUN: begin
                if (iABORT)        state_nxt = S_DRAIN;
                else if (fht_done) state_nxt = S_UNLOAD;
                else if (tmo_hit)  state_nxt = S_IDLE;
            end
            S_UNLOAD: begin
                if (iABORT || unl_last_rd) state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (iFHT_RDY || tmo_hit) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        oLOAD_READY = 1'b0;
        oFHT_START  = 1'b0;
        oRAM_OWNER  = 2'd0;
        oUNL_SET    = 1'b0;
        case (state)
            S_LOAD: begin
                oLOAD_READY = 1'b1;
                oRAM_OWNER  = 2'd1;
            end
            S_START: begin
                oFHT_START = 1'b1;
                oRAM_OWNER = 2'd2;
            end
            S_RUN, S_DRAIN: begin
                oRAM_OWNER = 2'd2;
            end
            S_UNLOAD: begin
                oRAM_OWNER = 2'd3;
                oUNL_SET   = result_set;
            end
            default: begin
                oRAM_OWNER = 2'd0;
            end
        endcase
    end

    // Load index; restarts from zero on any exit from LOAD, including abort
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            ld_cnt <= '0;
        end else if ((state != S_LOAD) || iABORT) begin
            ld_cnt <= '0;
        end else if (ld_we) begin
            ld_cnt <= ld_cnt + 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            unl_cnt <= '0;
        end else if ((state != S_UNLOAD) || iABORT) begin
            unl_cnt <= '0;
        end else if (unl_rd) begin
            unl_cnt <= unl_cnt + 1'b1;
        end
    end

    // Watchdog timer runs only while the FHT core owns the banks
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            tmo_cnt <= 16'd0;
        end else if ((state == S_RUN) || (state == S_DRAIN)) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end else begin
            tmo_cnt <= 16'd0;
        end
    end

    // The core's ping-pong select while busy tells which set holds the result
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            result_set <= 1'b0;
        end else if ((state == S_RUN) && !iFHT_RDY) begin
            result_set <= iFHT_SOURCE;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            err_q <= 1'b0;
        end else if (state == S_START) begin
            err_q <= 1'b0;
        end else if (tmo_exit) begin
            err_q <= 1'b1;
        end
    end

    // RAM read latency is one cycle
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            unl_valid_q <= 1'b0;
            unl_last_q  <= 1'b0;
        end else begin
            unl_valid_q <= unl_rd;
            unl_last_q  <= unl_last_rd;
        end
    end

    assign oLD_WE      = ld_we;
    assign oLD_BANK    = ld_cnt[1:0];
    assign oLD_ADDR    = ld_cnt[CW-1:2];
    assign oUNL_RD     = unl_rd;
    assign oUNL_BANK   = unl_cnt[1:0];
    assign oUNL_ADDR   = unl_cnt[CW-1:2];
    assign oUNL_VALID  = unl_valid_q;
    assign oUNL_LAST   = unl_last_q;
    assign oFRAME_DONE = fht_done && !iABORT;
    assign oBUSY       = (state != S_IDLE);
    assign oERR        = err_q;
    assign oSTATE      = state;

endmodule
